// File: rtl/dadda4_mac_seq.sv
// dadda4_mac_seq
//   Sequential multiply-accumulate front end for an external 4x4 Dadda
//   multiplier (dadda4). Operand pairs arrive over a valid/ready handshake.
//   Each accepted pair is registered onto the multiplier inputs. The 8-bit
//   product returned on mult_z is summed into an ACC_W-bit accumulator. One
//   result is presented per burst on a valid/ready output.
//
// Parameters
//   ACC_W     accumulator/result width (8..32)
//   CNT_W     term-counter width
//   SATURATE  1: clamp the accumulator on overflow, 0: wrap modulo 2^ACC_W
//
// Ports
//   clk, rst_n              clock (rising edge), async active-low reset
//   in_valid/in_ready       operand handshake; in_a, in_b, in_last are the payload
//   mult_a/mult_b           registered operands driven to dadda4
//   mult_z                  dadda4 product (combinational from mult_a/mult_b)
//   out_valid/out_ready     result handshake
//   out_sum                 accumulated sum of products
//   out_count               number of terms in the burst (saturating)
//   out_ovf                 sticky overflow flag for the burst
module dadda4_mac_seq #(
    parameter int ACC_W    = 12,
    parameter int CNT_W    = 8,
    parameter int SATURATE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_a,
    input  logic [3:0]       in_b,
    input  logic             in_last,
    output logic [3:0]       mult_a,
    output logic [3:0]       mult_b,
    input  logic [7:0]       mult_z,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic [CNT_W-1:0] out_count,
    output logic             out_ovf
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       mult_a_q, mult_a_d;
    logic [3:0]       mult_b_q, mult_b_d;
    logic             p_valid_q, p_valid_d;
    logic             p_last_q, p_last_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             out_valid_q, out_valid_d;

    logic             in_fire;
    logic             out_fire;
    logic [ACC_W:0]   acc_sum;

    // No new pair is taken while the last product of a burst is still in
    // flight, so terms of consecutive bursts can never mix.
    assign in_ready = (state_q != DONE) && !(p_valid_q && p_last_q);
    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid_q && out_ready;

    // One extra bit captures the carry-out used for overflow detection.
    assign acc_sum = {1'b0, acc_q} + {{(ACC_W-7){1'b0}}, mult_z};

    always_comb begin
        state_d     = state_q;
        mult_a_d    = mult_a_q;
        mult_b_d    = mult_b_q;
        p_valid_d   = 1'b0;
        p_last_d    = p_last_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;

        if (in_fire) begin
            mult_a_d  = in_a;
            mult_b_d  = in_b;
            p_valid_d = 1'b1;
            p_last_d  = in_last;
        end

        case (state_q)
            IDLE: begin
                if (in_fire) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (p_valid_q) begin
                    if (acc_sum[ACC_W]) begin
                        ovf_d = 1'b1;
                        acc_d = (SATURATE != 0) ? {ACC_W{1'b1}} : acc_sum[ACC_W-1:0];
                    end else begin
                        acc_d = acc_sum[ACC_W-1:0];
                    end
                    if (cnt_q != {CNT_W{1'b1}}) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                    // The last product is added on the same edge that ends the burst.
                    if (p_last_q) begin
                        state_d     = DONE;
                        out_valid_d = 1'b1;
                    end
                end
            end
            DONE: begin
                if (out_fire) begin
                    acc_d       = '0;
                    cnt_d       = '0;
                    ovf_d       = 1'b0;
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d     = IDLE;
                acc_d       = '0;
                cnt_d       = '0;
                ovf_d       = 1'b0;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mult_a_q    <= '0;
            mult_b_q    <= '0;
            p_valid_q   <= 1'b0;
            p_last_q    <= 1'b0;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mult_a_q    <= mult_a_d;
            mult_b_q    <= mult_b_d;
            p_valid_q   <= p_valid_d;
            p_last_q    <= p_last_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign mult_a    = mult_a_q;
    assign mult_b    = mult_b_q;
    assign out_valid = out_valid_q;
    assign out_sum   = acc_q;
    assign out_count = cnt_q;
    assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_dadda4_mac_seq.sv
// tb_dadda4_mac_seq
//   Directed bench for dadda4_mac_seq. Three instances share one stimulus
//   stream: the default build (12-bit, saturating), a 10-bit saturating build
//   and a 10-bit wrapping build. Each gets a behavioural 4x4 multiplier on its
//   mult_z input in place of dadda4.
module tb_dadda4_mac_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [3:0]  in_a = '0;
    logic [3:0]  in_b = '0;
    logic        in_last = 1'b0;
    logic        out_ready = 1'b0;

    logic        in_ready0, in_ready1, in_ready2;
    logic [3:0]  ma0, mb0, ma1, mb1, ma2, mb2;
    logic [7:0]  z0, z1, z2;
    logic        ov0, ov1, ov2;
    logic [11:0] sum0;
    logic [9:0]  sum1, sum2;
    logic [7:0]  cnt0, cnt1, cnt2;
    logic        ovf0, ovf1, ovf2;

    int vectorCount = 0;
    int missCount = 0;

    always #5 clk = ~clk;

    // Stand-ins for dadda4: plain unsigned products.
    assign z0 = ma0 * mb0;
    assign z1 = ma1 * mb1;
    assign z2 = ma2 * mb2;

    dadda4_mac_seq #(.ACC_W(12), .CNT_W(8), .SATURATE(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
        .in_a(in_a), .in_b(in_b), .in_last(in_last),
        .mult_a(ma0), .mult_b(mb0), .mult_z(z0),
        .out_valid(ov0), .out_ready(out_ready),
        .out_sum(sum0), .out_count(cnt0), .out_ovf(ovf0)
    );

    dadda4_mac_seq #(.ACC_W(10), .CNT_W(8), .SATURATE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
        .in_a(in_a), .in_b(in_b), .in_last(in_last),
        .mult_a(ma1), .mult_b(mb1), .mult_z(z1),
        .out_valid(ov1), .out_ready(out_ready),
        .out_sum(sum1), .out_count(cnt1), .out_ovf(ovf1)
    );

    dadda4_mac_seq #(.ACC_W(10), .CNT_W(8), .SATURATE(0)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
        .in_a(in_a), .in_b(in_b), .in_last(in_last),
        .mult_a(ma2), .mult_b(mb2), .mult_z(z2),
        .out_valid(ov2), .out_ready(out_ready),
        .out_sum(sum2), .out_count(cnt2), .out_ovf(ovf2)
    );

    // Single comparison point: counts every check, reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectorCount++;
        if (got !== exp) begin
            missCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Present one pair at a falling edge once in_ready is high; the transfer
    // happens on the following rising edge. Leaves the bench at the next
    // falling edge with in_valid dropped.
    task automatic applyStimulus(input logic [3:0] a, input logic [3:0] b, input logic last);
        int budget = 0;
        while (!in_ready0 && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        if (!in_ready0) checkOutput("in_ready_timeout", 32'(in_ready0), 32'd1);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_last  = last;
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic waitResult();
        int budget = 0;
        while (!ov0 && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        checkOutput("out_valid_timeout", 32'(ov0), 32'd1);
    endtask

    task automatic releaseResult();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        // Reset state
        #1;
        checkOutput("rst_out_valid", 32'(ov0), 32'd0);
        checkOutput("rst_out_sum", 32'(sum0), 32'd0);
        checkOutput("rst_mult_a", 32'(ma0), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("rst_in_ready", 32'(in_ready0), 32'd1);

        // Test 1: four (15,15) back-to-back, latency check
        applyStimulus(4'd15, 4'd15, 1'b0);
        applyStimulus(4'd15, 4'd15, 1'b0);
        applyStimulus(4'd15, 4'd15, 1'b0);
        applyStimulus(4'd15, 4'd15, 1'b1);
        checkOutput("t1_valid_early", 32'(ov0), 32'd0);
        @(negedge clk);
        checkOutput("t1_valid_k1", 32'(ov0), 32'd1);
        checkOutput("t1_sum", 32'(sum0), 32'd900);
        checkOutput("t1_count", 32'(cnt0), 32'd4);
        checkOutput("t1_ovf", 32'(ovf0), 32'd0);
        checkOutput("t1_sum10s", 32'(sum1), 32'd900);
        checkOutput("t1_sum10w", 32'(sum2), 32'd900);
        releaseResult();

        // Test 2: five (15,15) -> 1125 overflows the 10-bit builds
        for (int i = 0; i < 5; i++) applyStimulus(4'd15, 4'd15, i == 4);
        waitResult();
        checkOutput("t2_sum12", 32'(sum0), 32'd1125);
        checkOutput("t2_ovf12", 32'(ovf0), 32'd0);
        checkOutput("t2_sum_sat", 32'(sum1), 32'd1023);
        checkOutput("t2_ovf_sat", 32'(ovf1), 32'd1);
        checkOutput("t2_sum_wrap", 32'(sum2), 32'd101);
        checkOutput("t2_ovf_wrap", 32'(ovf2), 32'd1);
        checkOutput("t2_count", 32'(cnt1), 32'd5);
        releaseResult();

        // Test 3: single pair (3,5,last)
        applyStimulus(4'd3, 4'd5, 1'b1);
        checkOutput("t3_in_ready_after", 32'(in_ready0), 32'd0);
        checkOutput("t3_valid_early", 32'(ov0), 32'd0);
        @(negedge clk);
        checkOutput("t3_valid", 32'(ov0), 32'd1);
        checkOutput("t3_sum", 32'(sum0), 32'd15);
        checkOutput("t3_count", 32'(cnt0), 32'd1);

        // Test 4: hold in DONE, then release
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("t4_hold_valid", 32'(ov0), 32'd1);
            checkOutput("t4_hold_sum", 32'(sum0), 32'd15);
            checkOutput("t4_hold_count", 32'(cnt0), 32'd1);
            checkOutput("t4_hold_in_ready", 32'(in_ready0), 32'd0);
        end
        releaseResult();
        checkOutput("t4_rel_valid", 32'(ov0), 32'd0);
        checkOutput("t4_rel_in_ready", 32'(in_ready0), 32'd1);
        checkOutput("t4_rel_sum", 32'(sum0), 32'd0);
        checkOutput("t4_rel_count", 32'(cnt0), 32'd0);

        // Test 5: gapped input, (2,7) then two idle cycles then (4,4,last)
        applyStimulus(4'd2, 4'd7, 1'b0);
        @(negedge clk);
        @(negedge clk);
        checkOutput("t5_gap_valid", 32'(ov0), 32'd0);
        applyStimulus(4'd4, 4'd4, 1'b1);
        waitResult();
        checkOutput("t5_sum", 32'(sum0), 32'd30);
        checkOutput("t5_count", 32'(cnt0), 32'd2);
        releaseResult();

        // Test 6: reset mid-burst
        applyStimulus(4'd1, 4'd2, 1'b0);
        applyStimulus(4'd3, 4'd3, 1'b0);
        rst_n = 1'b0;
        #1;
        checkOutput("t6_rst_sum", 32'(sum0), 32'd0);
        checkOutput("t6_rst_count", 32'(cnt0), 32'd0);
        checkOutput("t6_rst_mult_a", 32'(ma0), 32'd0);
        checkOutput("t6_rst_mult_b", 32'(mb0), 32'd0);
        checkOutput("t6_rst_valid", 32'(ov0), 32'd0);
        checkOutput("t6_rst_ovf", 32'(ovf0), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        applyStimulus(4'd1, 4'd1, 1'b1);
        waitResult();
        checkOutput("t6_sum", 32'(sum0), 32'd1);
        checkOutput("t6_count", 32'(cnt0), 32'd1);
        releaseResult();

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
